// File: rtl/maze_pkg.sv
// Shared types for the maze store: default size, cell codes, FSM states.
package maze_pkg;

    localparam int MAZE_WIDTH = 6;

    typedef logic [1:0] cell_t;

    localparam cell_t FREE    = 2'd0;
    localparam cell_t WALL    = 2'd1;
    localparam cell_t VISITED = 2'd2;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DUMP  = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/maze_store_if.sv
// Load / solver / dump signal bundle of maze_store.
// path_len exists only when MAZE_STORE_PATHLEN_EN is defined.
interface maze_store_if #(parameter int maze_width = 6);

    logic                  load_valid;
    logic [1:0]            load_data;
    logic                  load_ready;
    logic                  mem_ready;
    logic [maze_width-1:0] row;
    logic [maze_width-1:0] col;
    logic                  maze_oe;
    logic                  maze_we;
    logic                  maze_in;
    logic                  done;
    logic                  dump_valid;
    logic                  dump_ready;
    logic [maze_width-1:0] dump_row;
    logic [maze_width-1:0] dump_col;
    logic                  dump_end;
    logic                  wr_err;
`ifdef MAZE_STORE_PATHLEN_EN
    logic [2*maze_width:0] path_len;
`endif

    modport master (
        output load_valid, load_data, row, col, maze_oe, maze_we,
        output done, dump_ready,
        input  load_ready, mem_ready, maze_in, dump_valid,
        input  dump_row, dump_col, dump_end, wr_err
`ifdef MAZE_STORE_PATHLEN_EN
        , input path_len
`endif
    );

    modport slave (
        input  load_valid, load_data, row, col, maze_oe, maze_we,
        input  done, dump_ready,
        output load_ready, mem_ready, maze_in, dump_valid,
        output dump_row, dump_col, dump_end, wr_err
`ifdef MAZE_STORE_PATHLEN_EN
        , output path_len
`endif
    );

endinterface

// File: rtl/maze_ram.sv
// Single-port 2-bit cell RAM, registered read-first output.
// Guarded writes never overwrite a wall; the old content of the write is reported.
import maze_pkg::*;

module maze_ram #(
    parameter int aw = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic          we,
    input  logic          guard,
    input  logic [aw-1:0] addr,
    input  cell_t         wdata,
    output cell_t         rdata,
    output logic          wr_hit,
    output cell_t         wr_old
);

    cell_t mem [2**aw];
    cell_t cur;

    assign cur = mem[addr];

    always_ff @(posedge clk) begin
        if (we && !(guard && cur == WALL))
            mem[addr] <= wdata;
    end

    // Contents survive reset; only the status registers are cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= WALL;
            wr_hit <= 1'b0;
            wr_old <= FREE;
        end else begin
            if (re)
                rdata <= cur;
            wr_hit <= we && guard;
            if (we)
                wr_old <= cur;
        end
    end

endmodule

// File: rtl/maze_store.sv
// Maze cell store: bulk load, solver read/mark service, visited-cell dump.
// Define MAZE_STORE_PATHLEN_EN to add the path_len counter output.
import maze_pkg::*;

module maze_store #(
    parameter int maze_width = MAZE_WIDTH
) (
    input logic         clk,
    input logic         rst,
    maze_store_if.slave bus
);

    localparam int AW = 2 * maze_width;
    localparam logic [AW-1:0] LAST = '1;

    state_t        state, nxt;
    logic [AW-1:0] load_addr, scan_addr, paddr, addr;
    logic          scan_done, pv;
    logic          serve, dumping, loading;
    logic          re, we, vis, stall, issue, err_hit;
    cell_t         rdata, wr_old, wdata;
    logic          wr_hit, err_q;

    assign loading = state == LOAD;
    assign serve   = state == SERVE;
    assign dumping = state == DUMP;

    assign vis   = pv && rdata == VISITED;
    assign stall = vis && !bus.dump_ready;
    assign issue = dumping && !stall && !scan_done;

    assign re    = (serve && bus.maze_oe) || issue;
    assign we    = (loading && bus.load_valid) || (serve && bus.maze_we);
    assign wdata = serve ? VISITED
                 : (bus.load_data == 2'd3 ? WALL : cell_t'(bus.load_data));

    always_comb begin
        addr = {bus.row, bus.col};
        if (loading)
            addr = load_addr;
        else if (dumping)
            addr = scan_addr;
    end

    maze_ram #(.aw(AW)) u_ram (
        .clk    (clk),
        .rst    (rst),
        .re     (re),
        .we     (we),
        .guard  (serve),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .wr_hit (wr_hit),
        .wr_old (wr_old)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LOAD;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            LOAD:  if (bus.load_valid && load_addr == LAST) nxt = SERVE;
            SERVE: if (bus.done) nxt = DUMP;
            DUMP:  if (scan_done && !pv) nxt = FIN;
            FIN:   nxt = FIN;
        endcase
    end

    always_comb begin
        bus.load_ready = loading;
        bus.mem_ready  = serve;
        bus.maze_in    = serve ? (rdata == WALL) : 1'b1;
        bus.dump_valid = dumping && vis;
        bus.dump_end   = dumping && scan_done && !pv;
    end

    assign bus.dump_row = paddr[AW-1:maze_width];
    assign bus.dump_col = paddr[maze_width-1:0];

    assign err_hit    = wr_hit && wr_old == WALL;
    assign bus.wr_err = err_q || err_hit;

    // pv/paddr track the address whose read data sits in rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_addr <= '0;
            scan_addr <= '0;
            paddr     <= '0;
            scan_done <= 1'b0;
            pv        <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (loading && bus.load_valid)
                load_addr <= load_addr + 1'b1;
            if (serve && bus.done) begin
                scan_addr <= '0;
                scan_done <= 1'b0;
                pv        <= 1'b0;
            end else if (dumping && !stall) begin
                pv <= !scan_done;
                if (!scan_done) begin
                    paddr     <= scan_addr;
                    scan_addr <= scan_addr + 1'b1;
                    if (scan_addr == LAST)
                        scan_done <= 1'b1;
                end
            end
            if (err_hit)
                err_q <= 1'b1;
        end
    end

`ifdef MAZE_STORE_PATHLEN_EN
    logic [AW:0] plen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            plen <= '0;
        else if (wr_hit && wr_old == FREE)
            plen <= plen + 1'b1;
    end

    assign bus.path_len = plen;
`endif

endmodule

// File: tb/tb_maze_store.sv
// Directed bench for maze_store: load, serve, dump, async reset.
// Covers path_len when MAZE_STORE_PATHLEN_EN is defined.
module tb_maze_store;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    maze_store_if #(.maze_width(6)) bus ();

    maze_store #(.maze_width(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] code(input int a);
        if (a == 0)
            return 2'd3;
        if (a == 5 * 64 + 7)
            return 2'd1;
        return 2'd0;
    endfunction

    task automatic load_maze();
        for (int i = 0; i < 4096; i++) begin
            if (i % 7 == 3) begin
                bus.load_valid = 1'b0;
                tick();
            end
            bus.load_valid = 1'b1;
            bus.load_data  = code(i);
            if (i == 4095) begin
                chk("ready_before_last", bus.load_ready, 1);
                chk("mem_ready_before_last", bus.mem_ready, 0);
            end
            tick();
        end
        bus.load_valid = 1'b0;
        chk("mem_ready_after_load", bus.mem_ready, 1);
        chk("load_ready_after_load", bus.load_ready, 0);
    endtask

    task automatic rd(input int r, input int c);
        bus.row     = 6'(r);
        bus.col     = 6'(c);
        bus.maze_oe = 1'b1;
        tick();
        bus.maze_oe = 1'b0;
    endtask

    task automatic mark(input int r, input int c);
        bus.row     = 6'(r);
        bus.col     = 6'(c);
        bus.maze_we = 1'b1;
        tick();
        bus.maze_we = 1'b0;
    endtask

    task automatic finish_dump();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.dump_valid && n < 6000) begin
            tick();
            n++;
        end
        chk("dump_valid_seen", bus.dump_valid, 1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_load_ready"}, bus.load_ready, 1);
        chk({pfx, "_mem_ready"}, bus.mem_ready, 0);
        chk({pfx, "_maze_in"}, bus.maze_in, 1);
        chk({pfx, "_dump_valid"}, bus.dump_valid, 0);
        chk({pfx, "_dump_row"}, bus.dump_row, 0);
        chk({pfx, "_dump_col"}, bus.dump_col, 0);
        chk({pfx, "_dump_end"}, bus.dump_end, 0);
        chk({pfx, "_wr_err"}, bus.wr_err, 0);
`ifdef MAZE_STORE_PATHLEN_EN
        chk({pfx, "_path_len"}, bus.path_len, 0);
`endif
    endtask

    int er[3] = '{1, 1, 63};
    int ec[3] = '{1, 2, 0};

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = 2'd0;
        bus.row        = '0;
        bus.col        = '0;
        bus.maze_oe    = 1'b0;
        bus.maze_we    = 1'b0;
        bus.done       = 1'b0;
        bus.dump_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;

        // Phase A: load, serve, then reset in the middle of a dump.
        load_maze();
        chk("serve_maze_in_idle", bus.maze_in, 1);
        rd(5, 7);
        chk("read_wall_5_7", bus.maze_in, 1);
        rd(5, 8);
        chk("read_free_5_8", bus.maze_in, 0);
        tick();
        chk("maze_in_hold", bus.maze_in, 0);
        rd(0, 0);
        chk("code3_is_wall", bus.maze_in, 1);

        bus.row     = 6'd3;
        bus.col     = 6'd3;
        bus.maze_oe = 1'b1;
        bus.maze_we = 1'b1;
        tick();
        bus.maze_oe = 1'b0;
        bus.maze_we = 1'b0;
        chk("oe_we_pre_write", bus.maze_in, 0);
        chk("wr_err_after_free_write", bus.wr_err, 0);
        mark(3, 3);
        chk("rewrite_no_err", bus.wr_err, 0);
        mark(0, 0);
        chk("wall_write_err", bus.wr_err, 1);
        tick();
        tick();
        chk("wr_err_sticky", bus.wr_err, 1);
        rd(0, 0);
        chk("wall_unchanged", bus.maze_in, 1);
`ifdef MAZE_STORE_PATHLEN_EN
        chk("path_len", bus.path_len, 1);
`endif

        finish_dump();
        chk("maze_in_in_dump", bus.maze_in, 1);
        chk("mem_ready_in_dump", bus.mem_ready, 0);
        wait_valid();
        chk("a_dump_row", bus.dump_row, 3);
        chk("a_dump_col", bus.dump_col, 3);
        tick();
        chk("a_dump_hold", bus.dump_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        tick();
        check_reset_outputs("async_held");
        rst = 1'b0;

        // Phase B: reload and dump three marked cells under back-pressure.
        load_maze();
        chk("wr_err_cleared", bus.wr_err, 0);
        mark(1, 2);
        mark(63, 0);
        mark(1, 1);
        finish_dump();
        for (int k = 0; k < 3; k++) begin
            wait_valid();
            chk($sformatf("b_row%0d", k), bus.dump_row, er[k]);
            chk($sformatf("b_col%0d", k), bus.dump_col, ec[k]);
            for (int s = 0; s < 3; s++) begin
                tick();
                chk($sformatf("b_stall_valid%0d", k), bus.dump_valid, 1);
                chk($sformatf("b_stall_row%0d", k), bus.dump_row, er[k]);
                chk($sformatf("b_stall_col%0d", k), bus.dump_col, ec[k]);
            end
            bus.dump_ready = 1'b1;
            tick();
            bus.dump_ready = 1'b0;
        end
        begin
            int n = 0;
            int extra = 0;
            while (!bus.dump_end && n < 6000) begin
                if (bus.dump_valid)
                    extra++;
                tick();
                n++;
            end
            chk("extra_cells", extra, 0);
            chk("dump_end_seen", bus.dump_end, 1);
        end
        tick();
        chk("dump_end_pulse", bus.dump_end, 0);
        chk("fin_load_ready", bus.load_ready, 0);
        chk("fin_mem_ready", bus.mem_ready, 0);
        chk("fin_dump_valid", bus.dump_valid, 0);
        chk("fin_maze_in", bus.maze_in, 1);
        tick();
        tick();
        chk("fin_no_second_end", bus.dump_end, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/maze_store.md
MAZE_STORE -- requirements
Module: maze_store

Interface
REQ-001 SHALL have parameter maze_width, default 6, row/column index width; the maze is 2^maze_width x 2^maze_width cells.
REQ-002 SHALL have ports: clk in 1, system clock; rst in 1, reset.
REQ-003 SHALL have ports: load_valid in 1, load cell present; load_data in 2, cell code; load_ready out 1, cell accepted this cycle.
REQ-004 SHALL have ports: mem_ready out 1, load complete and solver may run; row, col in maze_width, cell address; maze_oe in 1, read strobe; maze_we in 1, mark-visited strobe; maze_in out 1, 1 = wall.
REQ-005 SHALL have ports: done in 1, solver finished; dump_valid out 1; dump_ready in 1; dump_row, dump_col out maze_width; dump_end out 1, one-cycle pulse after scan; wr_err out 1, sticky illegal-write flag.
REQ-006 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-007 SHALL encode cells as 0 free, 1 wall, 2 visited; load code 3 SHALL be stored as 1.
REQ-008 SHALL use FSM states LOAD, SERVE, DUMP, FIN; reset enters LOAD.
REQ-009 LOAD: load_ready = 1; each cycle with load_valid = 1 SHALL store load_data at the internal row-major address counter and increment it.
REQ-010 LOAD: the handshake accepting the final cell (address 2^(2*maze_width)-1) SHALL move the FSM to SERVE next cycle; load_ready SHALL then be 0.
REQ-011 SERVE: mem_ready = 1; maze_oe = 1 SHALL register maze_in = (cell[row][col] == 1) on the next rising edge; maze_in SHALL hold its value between reads.
REQ-012 SERVE: maze_we = 1 SHALL write 2 to cell[row][col] on the rising edge, except on wall cells, which SHALL be left unchanged and SHALL set wr_err.
REQ-013 maze_oe and maze_we high in the same cycle SHALL perform both; maze_in SHALL return the pre-write content.
REQ-014 maze_oe/maze_we outside SERVE SHALL be ignored; maze_in SHALL be 1 outside SERVE.
REQ-015 done = 1 sampled in SERVE SHALL move the FSM to DUMP, resetting the scan counter to 0; strobes in that same cycle SHALL still be performed.
REQ-016 DUMP: the scan SHALL visit every address row-major; each visited (code 2) cell SHALL be presented on dump_row/dump_col with dump_valid = 1, held stable until dump_ready = 1.
REQ-017 DUMP: non-visited cells SHALL be skipped at one address per cycle with dump_valid = 0.
REQ-018 After the last address is handled, dump_end SHALL pulse for one cycle and the FSM SHALL enter FIN, where it stays until reset.
REQ-019 Address counters SHALL be maze_width*2 bits wide, with row = upper half and col = lower half.
REQ-020 RAM read latency SHALL be one cycle; the DUMP datapath SHALL pipeline around that latency without dropping or duplicating cells.

Reset
REQ-021 rst SHALL asynchronously clear the FSM to LOAD, clear all counters and set outputs to load_ready 1, mem_ready 0, maze_in 1, dump_valid 0, dump_row/dump_col 0, dump_end 0, wr_err 0.
REQ-022 RAM contents SHALL NOT be cleared by reset; a reset mid-operation SHALL require a full reload.

Configuration
REQ-023 With MAZE_STORE_PATHLEN_EN defined, the block SHALL add output path_len (2*maze_width+1 bits, reset 0), incremented on each SERVE write that changes a free cell to visited.
REQ-024 Without MAZE_STORE_PATHLEN_EN, the block SHALL have no path_len port and no counter logic.

Structure
REQ-025 A shared package maze_pkg SHALL hold the default MAZE_WIDTH, the cell-code constants (FREE, WALL, VISITED) and the FSM state encoding.
REQ-026 Storage SHALL be a sub-module maze_ram: a single-port synchronous RAM of 2 bits x 2^(2*maze_width) cells with a registered read.

Verification
REQ-027 Stream a full 64x64 load with load_valid gaps -> mem_ready rises exactly one cycle after the 4096th handshake; load_ready is then 0.
REQ-028 With cell[5][7] = 1, drive oe at row 5, col 7 -> maze_in = 1 on the next edge; with cell[5][8] = 0, read it -> maze_in = 0.
REQ-029 Drive oe+we on free cell [3][3] -> maze_in = 0 and cell becomes 2; drive we on wall cell [0][0] -> cell stays 1 and wr_err = 1 (sticky).
REQ-030 Mark cells [1][1], [1][2] and [63][0] visited, assert done, and hold dump_ready low for 3 cycles -> the dump emits exactly those three cells in that order, each held stable, followed by one dump_end pulse and FIN.
REQ-031 Assert rst during the DUMP state -> all outputs reach their REQ-021 values immediately (asynchronous), and the FSM is in LOAD.
REQ-032 With MAZE_STORE_PATHLEN_EN defined, write the same free cell twice plus one wall cell -> path_len = 1.
